// File: rtl/vrat_ckpt.sv
// Vector register alias table with a circular FIFO of whole-table checkpoints.
// Reads are combinational from the registered table. Writes, checkpoint
// allocation, commit and restore all update on the rising clock edge.
module vrat_ckpt #(
  parameter  int TOTAL_ENTRIES = 32,
  parameter  int DATA_WIDTH    = 6,
  parameter  int RD_PORTS      = 3,
  parameter  int WR_PORTS      = 2,
  parameter  int CKPT_DEPTH    = 4,
  localparam int AW            = $clog2(TOTAL_ENTRIES),
  localparam int CW            = $clog2(CKPT_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 reconfigure,
  input  logic [WR_PORTS-1:0]                  write_en,
  input  logic [WR_PORTS-1:0][AW-1:0]          write_addr,
  input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  write_data,
  input  logic [RD_PORTS-1:0][AW-1:0]          read_addr,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  read_data,
  output logic [RD_PORTS-1:0]                  remapped,
  output logic [DATA_WIDTH-1:0]                mask_src,
  input  logic                                 ckpt_req,
  output logic                                 ckpt_ack,
  output logic [CW-1:0]                        ckpt_id,
  input  logic                                 commit_en,
  input  logic                                 restore_en,
  input  logic [CW-1:0]                        restore_id,
  output logic                                 restore_err,
  output logic                                 ckpt_full,
  output logic                                 ckpt_empty
);

  logic [TOTAL_ENTRIES-1:0][DATA_WIDTH-1:0] tbl;
  logic [TOTAL_ENTRIES-1:0][DATA_WIDTH-1:0] tbl_wr;
  logic [TOTAL_ENTRIES-1:0]                 remap;
  logic [TOTAL_ENTRIES-1:0]                 remap_wr;

  // Checkpoint storage holds data only, so it is never reset.
  logic [TOTAL_ENTRIES-1:0][DATA_WIDTH-1:0] slot_tbl   [CKPT_DEPTH];
  logic [TOTAL_ENTRIES-1:0]                 slot_remap [CKPT_DEPTH];

  logic [CW-1:0] head;
  logic [CW-1:0] tail;
  logic [CW:0]   count;
  logic [CW-1:0] rel;
  logic          live;
  logic          commit_ok;

  // Combinational read ports straight from the registered table (no bypass).
  always_comb begin
    read_data = '0;
    remapped  = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      read_data[r] = tbl[read_addr[r]];
      remapped[r]  = remap[read_addr[r]];
    end
  end

  // Table as it would look after this cycle's writes; later ports override earlier ones.
  always_comb begin
    tbl_wr   = tbl;
    remap_wr = remap;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (write_en[p]) begin
        tbl_wr[write_addr[p]]   = write_data[p];
        remap_wr[write_addr[p]] = 1'b1;
      end
    end
  end

  assign mask_src   = tbl[1];
  assign ckpt_full  = (count == (CW+1)'(CKPT_DEPTH));
  assign ckpt_empty = (count == '0);
  assign ckpt_id    = tail;
  assign ckpt_ack   = ckpt_req & ~ckpt_full & ~restore_en & ~reconfigure;
  assign commit_ok  = commit_en & ~ckpt_empty & ~restore_en & ~reconfigure;

  // Age of the requested slot relative to the oldest live checkpoint; the
  // subtraction wraps naturally because CKPT_DEPTH is a power of two.
  assign rel  = restore_id - head;
  assign live = ({1'b0, rel} < count);

  // Table, remapped bits, FIFO pointers and error pulse, in priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TOTAL_ENTRIES; i++) begin
        tbl[i] <= DATA_WIDTH'(i);
      end
      remap       <= '1;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      restore_err <= 1'b0;
    end else if (reconfigure) begin
      tbl         <= '0;
      remap       <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      restore_err <= 1'b0;
    end else if (restore_en) begin
      if (live) begin
        // Restoring drops the restored slot and every younger one.
        tbl         <= slot_tbl[restore_id];
        remap       <= slot_remap[restore_id];
        tail        <= restore_id;
        count       <= {1'b0, rel};
        restore_err <= 1'b0;
      end else begin
        tbl         <= tbl_wr;
        remap       <= remap_wr;
        restore_err <= 1'b1;
      end
    end else begin
      tbl         <= tbl_wr;
      remap       <= remap_wr;
      restore_err <= 1'b0;
      if (commit_ok) head <= head + CW'(1);
      if (ckpt_ack)  tail <= tail + CW'(1);
      count <= count + (CW+1)'(ckpt_ack) - (CW+1)'(commit_ok);
    end
  end

  // Snapshot capture includes the writes landing in the same cycle.
  always_ff @(posedge clk) begin
    if (ckpt_ack && !rst) begin
      slot_tbl[tail]   <= tbl_wr;
      slot_remap[tail] <= remap_wr;
    end
  end

endmodule

// File: tb/tb_vrat_ckpt.sv
// Testbench for vrat_ckpt: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the alias table and checkpoints.
module tb_vrat_ckpt;

  localparam int N  = 32;
  localparam int DW = 6;
  localparam int D  = 4;

  logic                clk = 1'b0;
  logic                rst, reconfigure;
  logic [1:0]          write_en;
  logic [1:0][4:0]     write_addr;
  logic [1:0][DW-1:0]  write_data;
  logic [2:0][4:0]     read_addr;
  logic [2:0][DW-1:0]  read_data;
  logic [2:0]          remapped;
  logic [DW-1:0]       mask_src;
  logic                ckpt_req, ckpt_ack;
  logic [1:0]          ckpt_id;
  logic                commit_en, restore_en;
  logic [1:0]          restore_id;
  logic                restore_err, ckpt_full, ckpt_empty;

  int vectors = 0;
  int errors  = 0;

  vrat_ckpt dut (
    .clk(clk), .rst(rst), .reconfigure(reconfigure),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data), .remapped(remapped),
    .mask_src(mask_src), .ckpt_req(ckpt_req), .ckpt_ack(ckpt_ack),
    .ckpt_id(ckpt_id), .commit_en(commit_en), .restore_en(restore_en),
    .restore_id(restore_id), .restore_err(restore_err),
    .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays for the table, a queue of snapshots
  // ordered oldest-first, and the slot number of the oldest snapshot.
  typedef struct {
    logic [DW-1:0] t [N];
    logic          r [N];
  } snap_t;

  logic [DW-1:0] mt [N];
  logic          mr [N];
  snap_t         ckq [$];
  int            mhead;
  logic          merr;

  task automatic model_writes();
    for (int p = 0; p < 2; p++) begin
      if (write_en[p]) begin
        mt[write_addr[p]] = write_data[p];
        mr[write_addr[p]] = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    snap_t s;
    int    idx;
    int    sz;
    sz = ckq.size();
    if (rst) begin
      for (int i = 0; i < N; i++) begin mt[i] = DW'(i % 64); mr[i] = 1'b1; end
      ckq.delete(); mhead = 0; merr = 1'b0;
    end else if (reconfigure) begin
      for (int i = 0; i < N; i++) begin mt[i] = '0; mr[i] = 1'b0; end
      ckq.delete(); mhead = 0; merr = 1'b0;
    end else if (restore_en) begin
      idx = (int'(restore_id) - mhead + D) % D;
      if (idx < sz) begin
        s  = ckq[idx];
        mt = s.t;
        mr = s.r;
        while (ckq.size() > idx) s = ckq.pop_back();
        merr = 1'b0;
      end else begin
        model_writes();
        merr = 1'b1;
      end
    end else begin
      model_writes();
      merr = 1'b0;
      if (commit_en && sz > 0) begin
        s = ckq.pop_front();
        mhead = (mhead + 1) % D;
      end
      if (ckpt_req && sz < D) begin
        s.t = mt;
        s.r = mr;
        ckq.push_back(s);
      end
    end
  endtask

  // Advance one clock with the currently driven inputs, keeping the model in step.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; reconfigure = 0; write_en = '0; write_addr = '0; write_data = '0;
    ckpt_req = 0; commit_en = 0; restore_en = 0; restore_id = '0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step(); rst = 0;
    read_addr[0] = 5'd0; read_addr[1] = 5'd1; read_addr[2] = 5'd31;
    #1;
    vectors++; if (read_data[0] !== 6'd0)  begin errors++; $display("FAIL reset_rd0: got %0d expected 0", read_data[0]); end
    vectors++; if (read_data[1] !== 6'd1)  begin errors++; $display("FAIL reset_rd1: got %0d expected 1", read_data[1]); end
    vectors++; if (read_data[2] !== 6'd31) begin errors++; $display("FAIL reset_rd31: got %0d expected 31", read_data[2]); end
    vectors++; if (remapped !== 3'b111)    begin errors++; $display("FAIL reset_remap: got %b expected 111", remapped); end
    vectors++; if (mask_src !== 6'd1)      begin errors++; $display("FAIL reset_mask: got %0d expected 1", mask_src); end
    vectors++; if ({ckpt_empty, ckpt_full, ckpt_ack, restore_err} !== 4'b1000)
      begin errors++; $display("FAIL reset_flags: got %b expected 1000", {ckpt_empty, ckpt_full, ckpt_ack, restore_err}); end
  endtask

  task automatic test_write_conflict();
    idle();
    write_en = 2'b11; write_addr[0] = 5'd5; write_addr[1] = 5'd5;
    write_data[0] = 6'd10; write_data[1] = 6'd20; read_addr[0] = 5'd5;
    #1;
    vectors++; if (read_data[0] !== 6'd5) begin errors++; $display("FAIL no_bypass: got %0d expected 5", read_data[0]); end
    step(); idle(); #1;
    vectors++; if (read_data[0] !== 6'd20) begin errors++; $display("FAIL port_priority: got %0d expected 20", read_data[0]); end
    vectors++; if (remapped[0] !== 1'b1)   begin errors++; $display("FAIL wr_remap: got %b expected 1", remapped[0]); end
  endtask

  task automatic test_ckpt_restore();
    idle();
    write_en = 2'b01; write_addr[0] = 5'd3; write_data[0] = 6'd40; ckpt_req = 1;
    read_addr[0] = 5'd3;
    #1;
    vectors++; if (ckpt_ack !== 1'b1) begin errors++; $display("FAIL ck_ack: got %b expected 1", ckpt_ack); end
    vectors++; if (ckpt_id !== 2'd0)  begin errors++; $display("FAIL ck_id: got %0d expected 0", ckpt_id); end
    step(); idle();
    write_en = 2'b10; write_addr[1] = 5'd3; write_data[1] = 6'd41;
    step(); idle(); #1;
    vectors++; if (read_data[0] !== 6'd41) begin errors++; $display("FAIL pre_restore: got %0d expected 41", read_data[0]); end
    restore_en = 1; restore_id = 2'd0;
    step(); idle(); #1;
    vectors++; if (read_data[0] !== 6'd40) begin errors++; $display("FAIL restored: got %0d expected 40", read_data[0]); end
    vectors++; if (ckpt_empty !== 1'b1)    begin errors++; $display("FAIL restore_empty: got %b expected 1", ckpt_empty); end
    vectors++; if (restore_err !== 1'b0)   begin errors++; $display("FAIL restore_noerr: got %b expected 0", restore_err); end
  endtask

  task automatic test_ckpt_full_wrap();
    idle();
    for (int i = 0; i < 4; i++) begin
      ckpt_req = 1; #1;
      vectors++; if (ckpt_ack !== 1'b1 || ckpt_id !== 2'(i))
        begin errors++; $display("FAIL fill_%0d: got ack %b id %0d expected ack 1 id %0d", i, ckpt_ack, ckpt_id, i); end
      step();
    end
    vectors++; if (ckpt_full !== 1'b1 || ckpt_empty !== 1'b0)
      begin errors++; $display("FAIL full_flag: got full %b empty %b expected 1 0", ckpt_full, ckpt_empty); end
    ckpt_req = 1; #1;
    vectors++; if (ckpt_ack !== 1'b0) begin errors++; $display("FAIL fifth_req: got %b expected 0", ckpt_ack); end
    step();
    ckpt_req = 1; commit_en = 1; #1;
    vectors++; if (ckpt_ack !== 1'b0) begin errors++; $display("FAIL commit_full_req: got %b expected 0", ckpt_ack); end
    step(); idle();
    vectors++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL after_commit: got %b expected 0", ckpt_full); end
    ckpt_req = 1; #1;
    vectors++; if (ckpt_ack !== 1'b1 || ckpt_id !== 2'd0)
      begin errors++; $display("FAIL wrap: got ack %b id %0d expected ack 1 id 0", ckpt_ack, ckpt_id); end
    step(); idle();
  endtask

  task automatic test_restore_err();
    // Head is 1 with four live slots; trim to slots 1,2 then add slot 3.
    idle(); restore_en = 1; restore_id = 2'd3; step(); idle();
    ckpt_req = 1; #1;
    vectors++; if (ckpt_ack !== 1'b1 || ckpt_id !== 2'd3)
      begin errors++; $display("FAIL regrow: got ack %b id %0d expected ack 1 id 3", ckpt_ack, ckpt_id); end
    step(); idle();
    restore_en = 1; restore_id = 2'd0;
    write_en = 2'b01; write_addr[0] = 5'd7; write_data[0] = 6'd33; read_addr[0] = 5'd7;
    step(); idle(); #1;
    vectors++; if (restore_err !== 1'b1)   begin errors++; $display("FAIL err_pulse: got %b expected 1", restore_err); end
    vectors++; if (read_data[0] !== 6'd33) begin errors++; $display("FAIL err_write: got %0d expected 33", read_data[0]); end
    vectors++; if (ckpt_full !== 1'b0 || ckpt_empty !== 1'b0)
      begin errors++; $display("FAIL err_count: got full %b empty %b expected 0 0", ckpt_full, ckpt_empty); end
    ckpt_req = 1; #1;
    vectors++; if (ckpt_ack !== 1'b1 || ckpt_id !== 2'd0)
      begin errors++; $display("FAIL err_tail: got ack %b id %0d expected ack 1 id 0", ckpt_ack, ckpt_id); end
    ckpt_req = 0;
    step();
    vectors++; if (restore_err !== 1'b0) begin errors++; $display("FAIL err_oneshot: got %b expected 0", restore_err); end
  endtask

  task automatic test_reconfigure();
    idle();
    reconfigure = 1; restore_en = 1; restore_id = 2'd1;
    write_en = 2'b11; write_addr[0] = 5'd9; write_data[0] = 6'd50;
    write_addr[1] = 5'd31; write_data[1] = 6'd51;
    step(); idle();
    read_addr[0] = 5'd0; read_addr[1] = 5'd9; read_addr[2] = 5'd31; #1;
    vectors++; if (read_data !== '0)    begin errors++; $display("FAIL reconf_data: got %h expected 0", read_data); end
    vectors++; if (remapped !== 3'b000) begin errors++; $display("FAIL reconf_remap: got %b expected 000", remapped); end
    vectors++; if (mask_src !== 6'd0)   begin errors++; $display("FAIL reconf_mask: got %0d expected 0", mask_src); end
    vectors++; if (ckpt_empty !== 1'b1 || restore_err !== 1'b0)
      begin errors++; $display("FAIL reconf_flags: got empty %b err %b expected 1 0", ckpt_empty, restore_err); end
  endtask

  task automatic test_random();
    int sz;
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      reconfigure = ($urandom_range(0, 59) == 0);
      restore_en  = ($urandom_range(0, 7) == 0);
      restore_id  = 2'($urandom_range(0, 3));
      commit_en   = ($urandom_range(0, 3) == 0);
      ckpt_req    = ($urandom_range(0, 2) == 0);
      write_en    = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        write_addr[p] = 5'($urandom_range(0, 31));
        write_data[p] = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 3) == 0) write_addr[1] = write_addr[0];
      for (int r = 0; r < 3; r++) read_addr[r] = 5'($urandom_range(0, 31));
      #1;
      sz = ckq.size();
      vectors++; if (ckpt_ack !== (ckpt_req && sz < D && !restore_en && !reconfigure))
        begin errors++; $display("FAIL rnd_ack c%0d: got %b expected %b", c, ckpt_ack, (ckpt_req && sz < D && !restore_en && !reconfigure)); end
      vectors++; if (ckpt_id !== 2'((mhead + sz) % D))
        begin errors++; $display("FAIL rnd_id c%0d: got %0d expected %0d", c, ckpt_id, (mhead + sz) % D); end
      vectors++; if (ckpt_full !== (sz == D) || ckpt_empty !== (sz == 0))
        begin errors++; $display("FAIL rnd_level c%0d: got full %b empty %b expected count %0d", c, ckpt_full, ckpt_empty, sz); end
      vectors++; if (restore_err !== merr)
        begin errors++; $display("FAIL rnd_err c%0d: got %b expected %b", c, restore_err, merr); end
      vectors++; if (mask_src !== mt[1])
        begin errors++; $display("FAIL rnd_mask c%0d: got %0d expected %0d", c, mask_src, mt[1]); end
      for (int r = 0; r < 3; r++) begin
        vectors++; if (read_data[r] !== mt[read_addr[r]] || remapped[r] !== mr[read_addr[r]])
          begin errors++; $display("FAIL rnd_read c%0d p%0d: got %0d/%b expected %0d/%b", c, r, read_data[r], remapped[r], mt[read_addr[r]], mr[read_addr[r]]); end
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    read_addr = '0;
    mhead = 0; merr = 1'b0;
    test_reset();
    test_write_conflict();
    test_ckpt_restore();
    test_ckpt_full_wrap();
    test_restore_err();
    test_reconfigure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vrat_ckpt.md
VRAT_CKPT -- requirements
Module: vrat_ckpt

Interface
REQ-001 Parameter TOTAL_ENTRIES, default 32, is the number of architectural vector registers; AW = clog2(TOTAL_ENTRIES).
REQ-002 Parameter DATA_WIDTH, default 6, is the physical-register tag width.
REQ-003 Parameter RD_PORTS, default 3, is the number of read ports.
REQ-004 Parameter WR_PORTS, default 2, is the number of write ports.
REQ-005 Parameter CKPT_DEPTH, default 4, is the number of checkpoints (power of two, >=2); CW = clog2(CKPT_DEPTH).
REQ-006 The module SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 reconfigure  input  1  clears table and all checkpoints.
REQ-010 write_en  input  WR_PORTS  per-port write enable.
REQ-011 write_addr  input  WR_PORTS x AW  per-port architectural index.
REQ-012 write_data  input  WR_PORTS x DATA_WIDTH  per-port physical tag.
REQ-013 read_addr  input  RD_PORTS x AW  per-port read index.
REQ-014 read_data  output  RD_PORTS x DATA_WIDTH  mapped tag.
REQ-015 remapped  output  RD_PORTS  remapped status of the addressed entry.
REQ-016 mask_src  output  DATA_WIDTH  tag currently mapped for entry 1.
REQ-017 ckpt_req  input  1  request a checkpoint of the table.
REQ-018 ckpt_ack  output  1  checkpoint accepted this cycle (combinational).
REQ-019 ckpt_id  output  CW  slot that will be or was allocated; valid when ckpt_ack=1.
REQ-020 commit_en  input  1  frees the oldest live checkpoint.
REQ-021 restore_en  input  1  restores the table from checkpoint restore_id.
REQ-022 restore_id  input  CW  checkpoint to restore.
REQ-023 restore_err  output  1  registered one-cycle pulse for a restore to a non-live slot.
REQ-024 ckpt_full  output  1  live count equals CKPT_DEPTH.
REQ-025 ckpt_empty  output  1  live count equals 0.

Function
REQ-026 Reads SHALL be combinational from the registered table, with no same-cycle write bypass.
REQ-027 Each enabled write port SHALL set entry[write_addr] to write_data and set remapped[write_addr] to 1 at the clock edge.
REQ-028 When two or more enabled ports address the same entry, the highest-numbered port SHALL win.
REQ-029 Checkpoints SHALL form a circular FIFO with head pointer (oldest), tail pointer (next free) and count (0..CKPT_DEPTH); both pointers wrap modulo CKPT_DEPTH.
REQ-030 ckpt_ack SHALL equal ckpt_req AND NOT ckpt_full AND NOT restore_en AND NOT reconfigure; ckpt_id SHALL equal tail.
REQ-031 On ckpt_ack, slot[tail] SHALL store the table and remapped vector including that cycle's writes; tail then advances and count increments.
REQ-032 A commit_en SHALL advance head and decrement count, but only when count>0, restore_en=0 and reconfigure=0; otherwise it is ignored.
REQ-033 A simultaneous accepted checkpoint and accepted commit SHALL leave count unchanged; a commit while full plus a request SHALL still be refused, since ckpt_full is the pre-edge value.
REQ-034 restore_id is live when (restore_id - head) mod CKPT_DEPTH < count.
REQ-035 A live restore SHALL load the table and remapped vector from slot[restore_id], discard that cycle's writes, set tail = restore_id and set count = (restore_id - head) mod CKPT_DEPTH.
REQ-036 A live restore therefore frees the restored checkpoint and all younger checkpoints.
REQ-037 A non-live restore SHALL change no state except driving restore_err=1 in the next cycle; writes that cycle still apply.
REQ-038 Priority SHALL be rst > reconfigure > restore > commit/checkpoint/writes.
REQ-039 reconfigure SHALL set every entry to 0, every remapped bit to 0, head = tail = count = 0, and ignore all writes that cycle.

Reset
REQ-040 On rst, entry[i] SHALL be i mod 2^DATA_WIDTH and every remapped bit 1.
REQ-041 On rst, head = tail = count = 0, so ckpt_empty=1, ckpt_full=0 and ckpt_ack=0.
REQ-042 On rst, restore_err SHALL be 0; checkpoint slot contents are don't-care.
REQ-043 A reset asserted mid-operation SHALL override every other input that cycle.

Verification
REQ-044 Reset, then read entries 0, 1, 31 -> read_data = 0, 1, 31; remapped = 1; mask_src = 1.
REQ-045 Same cycle: write_en=2'b11, both ports address 5, port0 data 10, port1 data 20 -> next cycle entry 5 = 20.
REQ-046 Write entry 3=40 with ckpt_req -> ckpt_id=0; write entry 3=41; restore_id=0 -> entry 3 reads 40; ckpt_empty=1.
REQ-047 Four ckpt_req -> ids 0,1,2,3; ckpt_full=1; fifth request gives ckpt_ack=0; after one commit, request gives ckpt_id=0 (wrap).
REQ-048 Live slots 1..3, restore_id=0 -> restore_err=1 next cycle; table, count and pointers unchanged.
REQ-049 reconfigure with restore_en and write_en -> all entries 0, remapped 0, ckpt_empty=1, restore_err stays 0.
